// File: rtl/serial_subtractor_16_bit.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// The result and borrow-out are published in one step when the last bit completes.
module serial_subtractor_16_bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             br;
    logic [WIDTH-1:0] acc;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] acc_next;

    // One full-subtractor cell, fed by the bit selected by the counter.
    always_comb begin
        a_bit         = a_reg[cnt];
        b_bit         = b_reg[cnt];
        d_bit         = a_bit ^ b_bit ^ br;
        br_next       = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        acc_next      = acc;
        acc_next[cnt] = d_bit;
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            br    <= 1'b0;
            acc   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        br    <= bin;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    br  <= br_next;
                    // The final bit goes straight to the outputs so diff never shows a partial value.
                    if (cnt == LAST) begin
                        diff  <= acc_next;
                        bout  <= br_next;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_16_bit.sv
// Directed self-checking bench for serial_subtractor_16_bit.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_serial_subtractor_16_bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;

    int checks;
    int errors;

    serial_subtractor_16_bit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and waits (bounded) for done; lat counts edges after acceptance.
    task automatic do_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_bin,
                         output int lat, output int busy_cnt);
        a     = op_a;
        b     = op_b;
        bin   = op_bin;
        start = 1'b1;
        tick();
        start    = 1'b0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        lat      = 0;
        while (lat < 40 && done !== 1'b1) begin
            tick();
            lat++;
            if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++;
        if (diff !== 16'h0000) begin errors++; $display("[TB] FAIL reset_diff got %h want 0000", diff); end
        checks++;
        if (bout !== 1'b0) begin errors++; $display("[TB] FAIL reset_bout got %b want 0", bout); end
    endtask

    task automatic test_basic();
        int lat;
        int bc;
        do_op(16'h001F, 16'h000C, 1'b0, lat, bc);
        checks++;
        if (lat !== 16) begin errors++; $display("[TB] FAIL basic_latency got %0d want 16", lat); end
        checks++;
        if (bc !== 16) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 16", bc); end
        checks++;
        if (diff !== 16'h0013) begin errors++; $display("[TB] FAIL basic_diff got %h want 0013", diff); end
        checks++;
        if (bout !== 1'b0) begin errors++; $display("[TB] FAIL basic_bout got %b want 0", bout); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_in_done got %b want 1", ready); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width got %b want 0", done); end
        checks++;
        if (diff !== 16'h0013) begin errors++; $display("[TB] FAIL basic_diff_hold got %h want 0013", diff); end
    endtask

    task automatic test_borrow();
        int lat;
        int bc;
        do_op(16'h000C, 16'h001F, 1'b0, lat, bc);
        checks++;
        if (diff !== 16'hFFED) begin errors++; $display("[TB] FAIL borrow_diff got %h want ffed", diff); end
        checks++;
        if (bout !== 1'b1) begin errors++; $display("[TB] FAIL borrow_bout got %b want 1", bout); end
        tick();
        do_op(16'h0000, 16'h0000, 1'b1, lat, bc);
        checks++;
        if (diff !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_diff got %h want ffff", diff); end
        checks++;
        if (bout !== 1'b1) begin errors++; $display("[TB] FAIL wrap_bout got %b want 1", bout); end
        tick();
    endtask

    task automatic test_borrow_in();
        int lat;
        int bc;
        do_op(16'hC61F, 16'h018C, 1'b1, lat, bc);
        checks++;
        if (lat !== 16) begin errors++; $display("[TB] FAIL bin_latency got %0d want 16", lat); end
        checks++;
        if (diff !== 16'hC492) begin errors++; $display("[TB] FAIL bin_diff got %h want c492", diff); end
        checks++;
        if (bout !== 1'b0) begin errors++; $display("[TB] FAIL bin_bout got %b want 0", bout); end
        tick();
    endtask

    task automatic test_busy_reject();
        int dones;
        logic [15:0] got_diff;
        logic        got_bout;
        dones    = 0;
        got_diff = 16'h0000;
        got_bout = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0001;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            if (cyc == 5) begin
                start = 1'b1;
                a     = 16'h0000;
                b     = 16'h0001;
            end
            if (cyc == 6) start = 1'b0;
            tick();
            if (done === 1'b1) begin
                dones++;
                got_diff = diff;
                got_bout = bout;
            end
        end
        checks++;
        if (dones !== 1) begin errors++; $display("[TB] FAIL reject_done_count got %0d want 1", dones); end
        checks++;
        if (got_diff !== 16'hFFFE) begin errors++; $display("[TB] FAIL reject_diff got %h want fffe", got_diff); end
        checks++;
        if (got_bout !== 1'b0) begin errors++; $display("[TB] FAIL reject_bout got %b want 0", got_bout); end
    endtask

    task automatic test_back_to_back();
        int lat;
        a     = 16'h1234;
        b     = 16'h0234;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        // start stays high; next operands are presented while the first one runs.
        a   = 16'h0001;
        b   = 16'h0002;
        lat = 0;
        while (lat < 40 && done !== 1'b1) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 16) begin errors++; $display("[TB] FAIL b2b_first_latency got %0d want 16", lat); end
        checks++;
        if (diff !== 16'h1000) begin errors++; $display("[TB] FAIL b2b_first_diff got %h want 1000", diff); end
        checks++;
        if (bout !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_bout got %b want 0", bout); end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_no_gap_busy got %b want 1", busy); end
        lat = 0;
        while (lat < 40 && done !== 1'b1) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 16) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d want 16", lat); end
        checks++;
        if (diff !== 16'hFFFF) begin errors++; $display("[TB] FAIL b2b_second_diff got %h want ffff", diff); end
        checks++;
        if (bout !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_bout got %b want 1", bout); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int bc;
        int dones;
        a     = 16'hFFFF;
        b     = 16'h0000;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (diff !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_diff got %h want 0000", diff); end
        checks++;
        if (bout !== 1'b0) begin errors++; $display("[TB] FAIL midreset_bout got %b want 0", bout); end
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_busy_ready got %b%b want 01", busy, ready);
        end
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("[TB] FAIL midreset_no_done got %0d want 0", dones); end
        do_op(16'h0005, 16'h0003, 1'b0, lat, bc);
        checks++;
        if (lat !== 16) begin errors++; $display("[TB] FAIL post_reset_latency got %0d want 16", lat); end
        checks++;
        if (diff !== 16'h0002 || bout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_result got %h/%b want 0002/0", diff, bout);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = 16'h0000;
        b      = 16'h0000;
        bin    = 1'b0;
        #12;
        test_reset();
        #2;
        rst_n = 1'b1;
        tick();
        test_basic();
        test_borrow();
        test_borrow_in();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
